// File: rtl/ltl_mon_pkg.sv
// Shared types, defaults and helpers for the LTL monitor cluster.
// Struct fields are sized for the largest legal configuration; users slice down.
package ltl_mon_pkg;

    localparam int unsigned N_PROP_DEF = 7;
    localparam int unsigned N_ACC_DEF  = 4;
    localparam int unsigned HIT_W_DEF  = 8;
    localparam int unsigned TS_W_DEF   = 16;

    localparam int unsigned PROP_MAX   = 32;
    localparam int unsigned IDX_MAX_W  = 5;
    localparam int unsigned TS_MAX_W   = 32;

    typedef enum logic {
        RPT_IDLE = 1'b0,
        RPT_HOLD = 1'b1
    } rpt_state_e;

    typedef struct packed {
        logic [IDX_MAX_W-1:0] idx;
        logic [TS_MAX_W-1:0]  ts;
    } ltl_evt_t;

    // Lowest set index wins so the reported property is deterministic.
    function automatic logic [IDX_MAX_W-1:0] lowest_set_idx(input logic [PROP_MAX-1:0] v);
        logic [IDX_MAX_W-1:0] idx;
        idx = '0;
        for (int i = PROP_MAX - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_MAX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ltl_monitor_cluster_if.sv
// Event report channel from the monitor cluster to the trace/interrupt unit.
interface ltl_monitor_cluster_if #(
    parameter int unsigned IDX_W = 3,
    parameter int unsigned TS_W  = 16
);
    logic             evt_valid;
    logic             evt_ready;
    logic [IDX_W-1:0] evt_idx;
    logic [TS_W-1:0]  evt_time;

    modport master (output evt_valid, output evt_idx, output evt_time, input evt_ready);
    modport slave  (input evt_valid, input evt_idx, input evt_time, output evt_ready);
endinterface

// File: rtl/ltl_prop_slice.sv
// One property: tap OR reduction, pulse/sticky verdict register and saturating hit counter.
module ltl_prop_slice #(
    parameter int unsigned N_ACC = 4,
    parameter int unsigned HIT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_i,
    input  logic [N_ACC-1:0] taps_i,
    input  logic             en_i,
    input  logic             sticky_i,
    input  logic             clear_i,
    output logic             verdict_o,
    output logic [HIT_W-1:0] cnt_o,
    output logic             hit_c_o
);
    logic             verdict_q, verdict_d;
    logic [HIT_W-1:0] cnt_q, cnt_d;
    logic             hit;

    assign hit = run_i & en_i & (|taps_i);

    // A hit beats a simultaneous clear in sticky mode.
    always_comb begin
        verdict_d = hit;
        cnt_d     = cnt_q;
        if (sticky_i) verdict_d = hit | (verdict_q & ~clear_i);
        if (hit && (cnt_q != {HIT_W{1'b1}})) cnt_d = cnt_q + HIT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            verdict_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            verdict_q <= verdict_d;
            cnt_q     <= cnt_d;
        end
    end

    assign verdict_o = verdict_q;
    assign cnt_o     = cnt_q;
    assign hit_c_o   = hit;
endmodule

// File: rtl/ltl_monitor_cluster.sv
// Runtime-verification cluster: per-property verdicts and hit counters plus a
// single-slot timestamped event report with a drop counter for back-pressure.
module ltl_monitor_cluster
    import ltl_mon_pkg::*;
#(
    parameter int unsigned N_PROP = N_PROP_DEF,
    parameter int unsigned N_ACC  = N_ACC_DEF,
    parameter int unsigned HIT_W  = HIT_W_DEF,
    parameter int unsigned TS_W   = TS_W_DEF,
    parameter int unsigned IDX_W  = (N_PROP > 1) ? $clog2(N_PROP) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic [N_PROP*N_ACC-1:0] acc_taps,
    input  logic [N_PROP-1:0]       en_mask,
    input  logic [N_PROP-1:0]       sticky_mask,
    input  logic [N_PROP-1:0]       clear,
    output logic [N_PROP-1:0]       ltl_out,
    output logic [N_PROP*HIT_W-1:0] hit_cnt,
    ltl_monitor_cluster_if.master   evt,
    output logic [HIT_W-1:0]        drop_cnt
);
    logic [N_PROP-1:0] hit_c;
    rpt_state_e        state_q, state_d;
    ltl_evt_t          evt_q, evt_d;
    logic [HIT_W-1:0]  drop_q, drop_d;
    logic [TS_W-1:0]   ts_q, ts_d;
    logic              any_hit;
    logic              unused_evt_bits;

    for (genvar p = 0; p < N_PROP; p++) begin : g_prop
        ltl_prop_slice #(.N_ACC(N_ACC), .HIT_W(HIT_W)) u_slice (
            .clk       (clk),
            .reset     (reset),
            .run_i     (run),
            .taps_i    (acc_taps[p*N_ACC +: N_ACC]),
            .en_i      (en_mask[p]),
            .sticky_i  (sticky_mask[p]),
            .clear_i   (clear[p]),
            .verdict_o (ltl_out[p]),
            .cnt_o     (hit_cnt[p*HIT_W +: HIT_W]),
            .hit_c_o   (hit_c[p])
        );
    end

    assign any_hit = |hit_c;

    // Report FSM; every hit cycle seen while holding (accept cycle included) is a drop.
    always_comb begin
        state_d = state_q;
        evt_d   = evt_q;
        drop_d  = drop_q;
        ts_d    = run ? ts_q + TS_W'(1) : ts_q;
        unique case (state_q)
            RPT_IDLE: begin
                if (any_hit) begin
                    evt_d.idx = lowest_set_idx(PROP_MAX'(hit_c));
                    evt_d.ts  = TS_MAX_W'(ts_q);
                    state_d   = RPT_HOLD;
                end
            end
            RPT_HOLD: begin
                if (any_hit && (drop_q != {HIT_W{1'b1}})) drop_d = drop_q + HIT_W'(1);
                if (evt.evt_ready) state_d = RPT_IDLE;
            end
            default: state_d = RPT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= RPT_IDLE;
            evt_q   <= '0;
            drop_q  <= '0;
            ts_q    <= '0;
        end else begin
            state_q <= state_d;
            evt_q   <= evt_d;
            drop_q  <= drop_d;
            ts_q    <= ts_d;
        end
    end

    assign evt.evt_valid = (state_q == RPT_HOLD);
    assign evt.evt_idx   = evt_q.idx[IDX_W-1:0];
    assign evt.evt_time  = evt_q.ts[TS_W-1:0];
    assign drop_cnt      = drop_q;
    assign unused_evt_bits = ^evt_q;
endmodule

// File: tb/tb_ltl_monitor_cluster.sv
// Directed bench for ltl_monitor_cluster with a scoreboard on the event report port.
module tb_ltl_monitor_cluster;
    localparam int unsigned NP = 7;
    localparam int unsigned NA = 4;
    localparam int unsigned HW = 8;
    localparam int unsigned TW = 4;
    localparam int unsigned IW = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             run = 1'b0;
    logic [NP*NA-1:0] acc_taps = '0;
    logic [NP-1:0]    en_mask = '0;
    logic [NP-1:0]    sticky_mask = '0;
    logic [NP-1:0]    clear = '0;
    logic [NP-1:0]    ltl_out;
    logic [NP*HW-1:0] hit_cnt;
    logic [HW-1:0]    drop_cnt;

    ltl_monitor_cluster_if #(.IDX_W(IW), .TS_W(TW)) evt_if ();

    ltl_monitor_cluster #(.N_PROP(NP), .N_ACC(NA), .HIT_W(HW), .TS_W(TW), .IDX_W(IW)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .acc_taps    (acc_taps),
        .en_mask     (en_mask),
        .sticky_mask (sticky_mask),
        .clear       (clear),
        .ltl_out     (ltl_out),
        .hit_cnt     (hit_cnt),
        .evt         (evt_if),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int t;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   m_ts = 0;
    int   t0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int hc(input int p);
        return int'(hit_cnt[p*HW +: HW]);
    endfunction

    function automatic logic [NP*NA-1:0] tap(input int p, input int a);
        logic [NP*NA-1:0] v;
        v = '0;
        v[p*NA + a] = 1'b1;
        return v;
    endfunction

    task automatic push(input int idx);
        sb.push_back('{idx, m_ts});
    endtask

    // Inputs change at negedge; outputs are read at the following negedge.
    task automatic step();
        @(posedge clk);
        if (!reset) m_ts = 0;
        else if (run) m_ts = (m_ts + 1) % 16;
        @(negedge clk);
    endtask

    // Monitor: a valid & ready seen here is a handshake at the coming edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (evt_if.evt_valid && evt_if.evt_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL evt_unexpected idx=%0d time=%0d required=none", evt_if.evt_idx, evt_if.evt_time);
                end else begin
                    mon_e = sb.pop_front();
                    chk("evt_idx", longint'(evt_if.evt_idx), longint'(mon_e.idx));
                    chk("evt_time", longint'(evt_if.evt_time), longint'(mon_e.t));
                end
            end
        end
    end

    initial begin
        evt_if.evt_ready = 1'b1;
        @(negedge clk);
        step();
        step();
        chk("rst_ltl_out", longint'(ltl_out), 0);
        chk("rst_hit_cnt", longint'(hit_cnt), 0);
        chk("rst_evt_valid", longint'(evt_if.evt_valid), 0);
        chk("rst_evt_idx", longint'(evt_if.evt_idx), 0);
        chk("rst_evt_time", longint'(evt_if.evt_time), 0);
        chk("rst_drop", longint'(drop_cnt), 0);

        // Single pulse hit on property 3 at ts=5
        reset = 1'b1; run = 1'b1; en_mask = 7'h7F;
        for (int i = 0; i < 5; i++) step();
        acc_taps = tap(3, 2);
        push(3);
        step();
        acc_taps = '0;
        chk("t1_ltl_out", longint'(ltl_out), 8);
        chk("t1_valid", longint'(evt_if.evt_valid), 1);
        chk("t1_idx", longint'(evt_if.evt_idx), 3);
        chk("t1_time", longint'(evt_if.evt_time), 5);
        chk("t1_hit_cnt3", hc(3), 1);
        step();
        chk("t1_pulse_gone", longint'(ltl_out), 0);
        chk("t1_valid_gone", longint'(evt_if.evt_valid), 0);

        // Sticky verdict and clear priority
        sticky_mask = 7'h01;
        acc_taps = tap(0, 0);
        push(0);
        step();
        acc_taps = '0;
        chk("t2_set", longint'(ltl_out[0]), 1);
        for (int i = 0; i < 10; i++) step();
        chk("t2_hold10", longint'(ltl_out[0]), 1);
        acc_taps = tap(0, 3); clear = 7'h01;
        push(0);
        step();
        chk("t2_hit_and_clear", longint'(ltl_out[0]), 1);
        acc_taps = '0;
        step();
        clear = '0;
        chk("t2_clear", longint'(ltl_out[0]), 0);
        chk("t2_hit_cnt0", hc(0), 2);
        sticky_mask = '0;
        step();

        // Simultaneous hits: lowest index reported, no drop
        acc_taps = tap(1, 0) | tap(4, 1) | tap(6, 3);
        push(1);
        step();
        acc_taps = '0;
        chk("t3_ltl_out", longint'(ltl_out), 64'h52);
        chk("t3_idx", longint'(evt_if.evt_idx), 1);
        chk("t3_cnt1", hc(1), 1);
        chk("t3_cnt4", hc(4), 1);
        chk("t3_cnt6", hc(6), 1);
        chk("t3_drop", longint'(drop_cnt), 0);
        step();

        // Back-pressure: first of 5 hits is held, the rest drop
        evt_if.evt_ready = 1'b0;
        acc_taps = tap(2, 1);
        t0 = m_ts;
        push(2);
        for (int i = 0; i < 5; i++) step();
        acc_taps = '0;
        chk("t4_valid", longint'(evt_if.evt_valid), 1);
        chk("t4_time", longint'(evt_if.evt_time), longint'(t0));
        chk("t4_drop", longint'(drop_cnt), 4);
        chk("t4_cnt2", hc(2), 5);
        step();
        step();
        chk("t4_time_stable", longint'(evt_if.evt_time), longint'(t0));
        chk("t4_valid_held", longint'(evt_if.evt_valid), 1);
        evt_if.evt_ready = 1'b1;
        step();
        chk("t4_valid_fall", longint'(evt_if.evt_valid), 0);

        // Saturation: 300 consecutive hits, capture/drop alternate
        acc_taps = tap(5, 0);
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) push(5);
            step();
        end
        acc_taps = '0;
        chk("t5_cnt5_sat", hc(5), 255);
        chk("t5_drop", longint'(drop_cnt), 154);
        chk("t5_valid", longint'(evt_if.evt_valid), 0);

        // Disabled property and run=0 produce nothing; ts frozen while stopped
        en_mask = 7'h77;
        acc_taps = tap(3, 1);
        step(); step(); step();
        chk("t7_en_out", longint'(ltl_out), 0);
        chk("t7_en_valid", longint'(evt_if.evt_valid), 0);
        chk("t7_en_cnt3", hc(3), 1);
        en_mask = 7'h7F;
        run = 1'b0;
        acc_taps = tap(3, 1) | tap(0, 2);
        t0 = m_ts;
        step(); step(); step();
        chk("t7_run_out", longint'(ltl_out), 0);
        chk("t7_run_valid", longint'(evt_if.evt_valid), 0);
        chk("t7_run_cnt3", hc(3), 1);
        run = 1'b1;
        acc_taps = tap(6, 0);
        push(6);
        step();
        acc_taps = '0;
        chk("t7_ts_frozen", longint'(evt_if.evt_time), longint'(t0));
        step();

        // Reset while holding a report
        evt_if.evt_ready = 1'b0;
        acc_taps = tap(1, 2);
        push(1);
        step();
        acc_taps = '0;
        chk("t8_valid_pre", longint'(evt_if.evt_valid), 1);
        reset = 1'b0;
        void'(sb.pop_back());
        step();
        chk("t8_valid", longint'(evt_if.evt_valid), 0);
        chk("t8_hit_cnt", longint'(hit_cnt), 0);
        chk("t8_drop", longint'(drop_cnt), 0);
        chk("t8_ltl_out", longint'(ltl_out), 0);
        evt_if.evt_ready = 1'b1;

        // Timestamp wrap: 17th run cycle is stamped 0
        reset = 1'b1;
        for (int i = 0; i < 16; i++) step();
        acc_taps = tap(1, 0);
        push(1);
        step();
        acc_taps = '0;
        chk("t6_wrap_time", longint'(evt_if.evt_time), 0);
        step(); step(); step();
        chk("sb_empty", longint'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ltl_monitor_cluster.md
# ltl_monitor_cluster

Parametrised runtime-verification cluster that turns raw accepting-state taps from a generated LTL automata stage into registered per-property verdicts. It generalises the fixed seven-property, four-tap cluster to N_PROP properties of N_ACC taps each. It adds per-property enable, pulse/sticky verdict modes, saturating hit counters, a free-running timestamp, and a valid/ready event report port for the trace/interrupt unit. It sits between the generated automata stage and the core's monitor CSR/trace logic.

## Interface
- N_PROP, 7: properties in cluster (1..32)
- N_ACC, 4: accepting-state taps per property
- HIT_W, 8: width of each hit counter and drop counter
- TS_W, 16: timestamp width
- IDX_W, $clog2(N_PROP) (min 1): event index width

- clk  in  1  clock, all logic rising-edge
- reset  in  1  synchronous, active-low; 0 at a rising edge clears all state
- run  in  1  taps valid this cycle; timestamp advances
- acc_taps  in  N_PROP*N_ACC  property p taps at [p*N_ACC +: N_ACC]
- en_mask  in  N_PROP  per-property enable
- sticky_mask  in  N_PROP  1 = sticky verdict, 0 = pulse verdict
- clear  in  N_PROP  clears sticky verdict p
- ltl_out  out  N_PROP  registered verdicts
- hit_cnt  out  N_PROP*HIT_W  per-property saturating hit counts
- evt_valid  out  1  event report valid
- evt_ready  in  1  consumer accepts report
- evt_idx  out  IDX_W  index of reported property
- evt_time  out  TS_W  timestamp of reported hit
- drop_cnt  out  HIT_W  saturating count of unreported hit cycles

## Operation
- hit[p] = run & en_mask[p] & |acc_taps[p*N_ACC +: N_ACC]. Combinational; never exposed.
- ts: increments by 1 each cycle run=1 and wraps mod 2^TS_W. A hit is stamped with ts before that cycle's increment.
- Pulse mode (sticky_mask[p]=0): ltl_out[p] <= hit[p].
- Sticky mode: ltl_out[p] set on hit[p], cleared on clear[p]. Simultaneous hit and clear leaves it set. clear has no effect in pulse mode.
- A sticky_mask change takes effect on the next edge and does not clear the current value.
- hit_cnt[p] increments on each hit[p] cycle and saturates at 2^HIT_W-1. It is not cleared by clear (reset only).
- Report FSM has two states:
  - IDLE: on any hit, capture the lowest set index p into evt_idx and the current ts into evt_time, then go to HOLD.
  - HOLD: evt_valid=1 and evt_idx/evt_time stay stable. When evt_valid & evt_ready, return to IDLE.
- Hit cycles in HOLD, including the accept cycle, are not reported. Each increments drop_cnt by 1 (saturating).
- Additional simultaneous hits in a capture cycle are not counted as drops; hit_cnt records them.
- The next capture happens at the earliest in the cycle after returning to IDLE.
- run=0: no hits, ts frozen. Pulse verdicts go to 0; sticky verdicts, counters and pending reports hold.

## Timing
- Reset values: ltl_out=0, hit_cnt=0, evt_valid=0, evt_idx=0, evt_time=0, drop_cnt=0, ts=0, FSM=IDLE.
- Latency: taps at edge k give ltl_out, hit_cnt and evt_valid at k+1. There is no combinational path from inputs to outputs.
- evt_ready is sampled only while evt_valid=1. evt_valid never drops without acceptance, except on reset.
- Reset mid-HOLD drops the pending report with no handshake.
- ts wrap from 2^TS_W-1 to 0 is silent.

## Structure
- Package ltl_mon_pkg holds:
  - the report FSM state enum
  - the ltl_evt_t struct {idx, time}
  - the function returning the lowest set index of an N_PROP vector
  - the default parameter constants
- One natural sub-module, ltl_prop_slice: per-property OR reduction, verdict register and hit counter, generated N_PROP times.
- The report FSM, timestamp and drop counter live in the top.

## Test plan
- Defaults. After reset (low 2 cycles): run=1, en_mask=7'h7F, sticky_mask=0, acc_taps tap 2 of property 3 for 1 cycle at ts=5. Required: ltl_out=7'h08 for exactly 1 cycle; evt_valid, evt_idx=3, evt_time=5; hit_cnt[3]=1.
- Sticky/clear. sticky_mask[0]=1, hit p0 once; ltl_out[0] stays 1 for 10 cycles. Assert clear[0] together with a hit: ltl_out[0] stays 1. Clear alone: it goes to 0 the next cycle.
- Simultaneous hits. Hit p1, p4 and p6 in the same cycle. Required: evt_idx=1, hit_cnt[1,4,6]=1 each, drop_cnt=0.
- Back-pressure. evt_ready=0, hit p2 on 5 consecutive cycles. Required: the first hit is reported with its timestamp held stable and drop_cnt=4. Raise evt_ready: evt_valid falls the next cycle.
- Saturation/wrap. HIT_W=8: 300 hits on p5 give hit_cnt[5]=255. TS_W=4: a hit at the 17th run cycle is stamped evt_time=0.
- Enable/run/reset. en_mask[3]=0 with taps active gives no response. run=0 with taps active gives no response and ts is frozen. Reset asserted in HOLD gives evt_valid=0 and all counters 0 the next cycle.
